// File: rtl/tdc_decoder.sv
// TDC back-end: 3-stage thermometer decoder (rise/fall search), block-averaged period and ACQ/TRACK/LOST tracking.
// Optional `TDC_BUBBLE_FILTER_EN: 3-tap majority bubble filter on interior taps in S1.
module tdc_decoder #(
    parameter int NTDC     = 64,
    parameter int PW       = 7,
    parameter int AVG_LOG2 = 4,
    parameter int MISS_MAX = 8
) (
    input  logic            ref_clk,
    input  logic            rst,
    input  logic [NTDC-1:0] sampled_tdc,
    input  logic            tdc_valid,
    output logic [PW-1:0]   tdc_rise,
    output logic [PW-1:0]   tdc_fall,
    output logic [PW-1:0]   half_period,
    output logic            edge_miss,
    output logic            out_valid,
    output logic [PW:0]     period_avg,
    output logic            cal_done,
    output logic            lost
);
    localparam int STAGES = 3;
    localparam int SW     = PW + 1 + AVG_LOG2;
    localparam int CW     = AVG_LOG2 + 1;
    localparam int MW     = $clog2(MISS_MAX + 1);
    localparam logic [PW-1:0] NONE = PW'(NTDC);

    typedef enum logic [1:0] {ACQ, TRACK, LOST} state_t;

    logic [STAGES-1:0] vld_pipe_q;
    logic [NTDC-1:0]   w_filt, w1_q;
    logic [PW-1:0]     rise_c, fall_c, rise2_q, fall2_q;
    logic [PW-1:0]     rise_q, fall_q, half_q, half_c;
    logic              miss_q;
    logic [PW:0]       avg_q, avg_d;
    logic [SW-1:0]     sum_q, sum_d, sum_n;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_n;
    logic [MW-1:0]     misscnt_q, misscnt_d;
    logic              cal_q, cal_d, lost_q, lost_d;
    logic              both, meas, miss, blk_done;
    state_t            state_q, state_d;

    // S1 input conditioning
    always_comb begin
        w_filt = sampled_tdc;
`ifdef TDC_BUBBLE_FILTER_EN
        for (int i = 1; i < NTDC - 1; i++)
            w_filt[i] = (sampled_tdc[i-1] & sampled_tdc[i]) |
                        (sampled_tdc[i-1] & sampled_tdc[i+1]) |
                        (sampled_tdc[i]   & sampled_tdc[i+1]);
`endif
    end

    // S2 priority search: scanning downward so the lowest index wins
    always_comb begin
        rise_c = NONE;
        fall_c = NONE;
        for (int i = NTDC - 1; i >= 1; i--) begin
            if (!w1_q[i-1] && w1_q[i]) rise_c = PW'(i);
            if (w1_q[i-1] && !w1_q[i]) fall_c = PW'(i);
        end
    end

    // S3 classification of the sample leaving S2
    always_comb begin
        both   = (rise2_q != NONE) && (fall2_q != NONE);
        meas   = vld_pipe_q[1] && both;
        miss   = vld_pipe_q[1] && (rise2_q == NONE) && (fall2_q == NONE);
        half_c = (rise2_q > fall2_q) ? rise2_q - fall2_q : fall2_q - rise2_q;
        sum_n  = sum_q + SW'({half_c, 1'b0});
        cnt_n  = cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        cal_d     = cal_q;
        lost_d    = lost_q;
        misscnt_d = misscnt_q;
        blk_done  = 1'b0;
        if (meas) begin
            misscnt_d = '0;
            if (state_q == LOST) begin
                state_d = ACQ;
                lost_d  = 1'b0;
            end
            if (cnt_n == CW'(1 << AVG_LOG2)) begin
                blk_done = 1'b1;
                avg_d    = sum_n[SW-1:AVG_LOG2];
                sum_d    = '0;
                cnt_d    = '0;
            end else begin
                sum_d = sum_n;
                cnt_d = cnt_n;
            end
            if (blk_done && state_d == ACQ) begin
                state_d = TRACK;
                cal_d   = 1'b1;
            end
        end else if (miss) begin
            if (misscnt_q != MW'(MISS_MAX)) misscnt_d = misscnt_q + 1'b1;
            if (misscnt_d == MW'(MISS_MAX) && state_q != LOST) begin
                state_d = LOST;
                cal_d   = 1'b0;
                lost_d  = 1'b1;
                sum_d   = '0;
                cnt_d   = '0;
            end
        end else if (vld_pipe_q[1]) begin
            misscnt_d = '0;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            w1_q       <= '0;
            rise2_q    <= NONE;
            fall2_q    <= NONE;
            rise_q     <= NONE;
            fall_q     <= NONE;
            half_q     <= '0;
            miss_q     <= 1'b0;
            avg_q      <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            misscnt_q  <= '0;
            cal_q      <= 1'b0;
            lost_q     <= 1'b0;
            state_q    <= ACQ;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-2:0], tdc_valid};
            w1_q       <= w_filt;
            rise2_q    <= rise_c;
            fall2_q    <= fall_c;
            if (vld_pipe_q[1]) begin
                rise_q <= rise2_q;
                fall_q <= fall2_q;
                if (both) half_q <= half_c;
            end
            miss_q     <= miss;
            avg_q      <= avg_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            misscnt_q  <= misscnt_d;
            cal_q      <= cal_d;
            lost_q     <= lost_d;
            state_q    <= state_d;
        end
    end

    assign tdc_rise    = rise_q;
    assign tdc_fall    = fall_q;
    assign half_period = half_q;
    assign edge_miss   = miss_q;
    assign out_valid   = vld_pipe_q[STAGES-1];
    assign period_avg  = avg_q;
    assign cal_done    = cal_q;
    assign lost        = lost_q;
endmodule

// File: tb/tb_tdc_decoder.sv
// Scoreboard bench for tdc_decoder: directed thermometer words, expected per-sample results queued at issue.
module tb_tdc_decoder;
    logic        ref_clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] sampled_tdc = '0;
    logic        tdc_valid = 1'b0;
    logic [6:0]  tdc_rise, tdc_fall, half_period;
    logic        edge_miss, out_valid, cal_done, lost;
    logic [7:0]  period_avg;

    tdc_decoder dut (
        .ref_clk(ref_clk), .rst(rst), .sampled_tdc(sampled_tdc), .tdc_valid(tdc_valid),
        .tdc_rise(tdc_rise), .tdc_fall(tdc_fall), .half_period(half_period),
        .edge_miss(edge_miss), .out_valid(out_valid), .period_avg(period_avg),
        .cal_done(cal_done), .lost(lost)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {int r; int f; int h; int m; int cyc;} exp_t;
    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   half_m = 0;

    localparam logic [63:0] W1030 = 64'h0000_0000_3FFF_FC00;  // bits 10..29
    localparam logic [63:0] W2050 = 64'h0003_FFFF_FFF0_0000;  // bits 20..49
    localparam logic [63:0] WONE  = 64'h0000_01FF_FFFF_FFFF;  // bits 0..40

    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge ref_clk) begin : monitor
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc - e.cyc, 3);
                chk("rise", int'(tdc_rise), e.r);
                chk("fall", int'(tdc_fall), e.f);
                chk("half_period", int'(half_period), e.h);
                chk("edge_miss", int'(edge_miss), e.m);
            end
        end
    end

    task automatic drive(input logic [63:0] w, input logic v, input int er, input int ef);
        exp_t e;
        @(posedge ref_clk); #1;
        sampled_tdc = w;
        tdc_valid   = v;
        if (v) begin
            if (er < 64 && ef < 64) half_m = (er > ef) ? er - ef : ef - er;
            e.r = er; e.f = ef; e.h = half_m;
            e.m = (er == 64 && ef == 64) ? 1 : 0;
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        @(posedge ref_clk); #1;
        tdc_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge ref_clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge ref_clk);
    endtask

    task automatic chk_state(input string tag, input int avg, input int cal, input int lst);
        chk({tag, "_period_avg"}, int'(period_avg), avg);
        chk({tag, "_cal_done"}, int'(cal_done), cal);
        chk({tag, "_lost"}, int'(lost), lst);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rise"}, int'(tdc_rise), 64);
        chk({tag, "_fall"}, int'(tdc_fall), 64);
        chk({tag, "_half"}, int'(half_period), 0);
        chk({tag, "_miss"}, int'(edge_miss), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk_state(tag, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge ref_clk);
        #1 rst = 1'b0;
        @(negedge ref_clk);
        chk_reset("reset");

        // 16 clean measurements complete the first block
        for (int i = 0; i < 16; i++) drive(W1030, 1'b1, 10, 30);
        drain();
        chk_state("block1", 40, 1, 0);

        // single-bit bubble inside the ones run
`ifdef TDC_BUBBLE_FILTER_EN
        drive(W1030 & ~(64'd1 << 15), 1'b1, 10, 30);
`else
        drive(W1030 & ~(64'd1 << 15), 1'b1, 10, 15);
`endif
        drain();

        // 8 edge-less samples force LOST; one measurement recovers to ACQ
        for (int i = 0; i < 7; i++) drive('0, 1'b1, 64, 64);
        drain();
        chk_state("pre_lost", 40, 1, 0);
        drive('0, 1'b1, 64, 64);
        drain();
        chk_state("lost", 40, 0, 1);
        drive(W1030, 1'b1, 10, 30);
        drain();
        chk_state("reacq", 40, 0, 0);

        // reset with three samples in flight: none of them may emerge
        @(posedge ref_clk); #1; sampled_tdc = W1030; tdc_valid = 1'b1;
        @(posedge ref_clk); #1;
        @(posedge ref_clk); #1; rst = 1'b1;
        @(posedge ref_clk); #1; rst = 1'b0; tdc_valid = 1'b0; half_m = 0;
        @(negedge ref_clk);
        chk_reset("midreset");
        repeat (4) @(negedge ref_clk);
        chk("midreset_quiet", int'(out_valid), 0);

        // gapped stream: 8 x 10/30 then 8 x 20/50 -> (320+480)/16
        for (int i = 0; i < 8; i++) begin
            drive(W1030, 1'b1, 10, 30);
            drive(W1030, 1'b0, 0, 0);
        end
        for (int i = 0; i < 7; i++) begin
            drive(W2050, 1'b1, 20, 50);
            drive(W2050, 1'b0, 0, 0);
        end
        drain();
        chk_state("block15", 0, 0, 0);
        drive(W2050, 1'b1, 20, 50);
        drain();
        chk_state("block2", 50, 1, 0);

        // a single-edge sample must clear the miss run without being a measurement
        for (int i = 0; i < 7; i++) drive('0, 1'b1, 64, 64);
        drive(WONE, 1'b1, 64, 41);
        for (int i = 0; i < 7; i++) drive('0, 1'b1, 64, 64);
        drain();
        chk_state("single_edge", 50, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
